// File: rtl/clock_prescaler_pkg.sv
// Shared definitions for the clock prescaler: FSM encodings and parameter defaults.
package clock_prescaler_pkg;

  // FSM state encodings (2-bit); the unused value 3 recovers to INIT
  localparam logic [1:0] INIT    = 2'd0;
  localparam logic [1:0] STARTUP = 2'd1;
  localparam logic [1:0] ACTIVE  = 2'd2;

  typedef enum logic [1:0] {
    ST_INIT    = INIT,
    ST_STARTUP = STARTUP,
    ST_ACTIVE  = ACTIVE
  } state_e;

  // Default parameter values
  localparam int DIV_WIDTH_DEF      = 8;
  localparam int NUM_CH_DEF         = 4;
  localparam int STARTUP_CYCLES_DEF = 128;

  // Width of the startup counter (STARTUP_CYCLES is limited to 2^16-1)
  localparam int STARTUP_CNT_W = 16;

endpackage

// File: rtl/prescaler_tick_cascade.sv
// Cascaded sub-rate tick channels: ch_pulse[k] fires once every 2^k base ticks.
// All channels fire together on the base tick where tick_cnt wraps.
module prescaler_tick_cascade #(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              tick,
  input  logic              en,
  output logic [NUM_CH-1:0] ch_pulse
);

  localparam int CNT_W = (NUM_CH > 1) ? NUM_CH - 1 : 1;

  logic [CNT_W-1:0]  tick_cnt_reg;
  logic [NUM_CH-1:0] ch_pulse_reg;
  logic [NUM_CH-1:0] fire_mask;

  // Channel k fires when the low k bits of tick_cnt are all ones before the increment
  assign fire_mask[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_CH; gi++) begin : g_mask
      assign fire_mask[gi] = &tick_cnt_reg[gi-1:0];
    end
  endgenerate

  // Advance the tick counter on each base tick and register the channel pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_reg <= '0;
      ch_pulse_reg <= '0;
    end else if (clear) begin
      tick_cnt_reg <= '0;
      ch_pulse_reg <= '0;
    end else if (en && tick) begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
      ch_pulse_reg <= fire_mask;
    end else begin
      ch_pulse_reg <= '0;
    end
  end

  assign ch_pulse = ch_pulse_reg;

endmodule

// File: rtl/clock_prescaler_gen.sv
// Programmable tick prescaler with startup-reset sequencing.
// Optional square-wave output clk_presc_sq is built when CLOCK_PRESCALER_SQUARE_EN is defined.
module clock_prescaler_gen
  import clock_prescaler_pkg::*;
#(
  parameter int DIV_WIDTH      = DIV_WIDTH_DEF,
  parameter int NUM_CH         = NUM_CH_DEF,
  parameter int STARTUP_CYCLES = STARTUP_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div_val,
  output logic                 clk_presc_pulse,
  output logic [NUM_CH-1:0]    ch_pulse,
  output logic                 reset_out,
  output logic                 busy_startup
`ifdef CLOCK_PRESCALER_SQUARE_EN
  ,
  output logic                 clk_presc_sq
`endif
);

  localparam logic [STARTUP_CNT_W-1:0] STARTUP_LAST = STARTUP_CNT_W'(STARTUP_CYCLES);

  state_e                   state_reg;
  logic [DIV_WIDTH-1:0]     base_cnt_reg;
  logic [DIV_WIDTH-1:0]     div_q_reg;
  logic [STARTUP_CNT_W-1:0] startup_cnt_reg;
  logic                     pulse_reg;
  logic                     reset_out_reg;
  logic                     busy_reg;
`ifdef CLOCK_PRESCALER_SQUARE_EN
  logic                     sq_reg;
`endif

  logic running;
  logic tick_evt;

  // Divider runs in STARTUP and ACTIVE; a tick is the terminal count with en high
  assign running  = (state_reg == ST_STARTUP) || (state_reg == ST_ACTIVE);
  assign tick_evt = running && en && (base_cnt_reg == div_q_reg);

  // Startup FSM plus base divider; the ratio reloads only at terminal count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_INIT;
      base_cnt_reg    <= '0;
      div_q_reg       <= '0;
      startup_cnt_reg <= '0;
      pulse_reg       <= 1'b0;
      reset_out_reg   <= 1'b0;
      busy_reg        <= 1'b1;
`ifdef CLOCK_PRESCALER_SQUARE_EN
      sq_reg          <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_INIT: begin
          div_q_reg       <= div_val;
          base_cnt_reg    <= '0;
          startup_cnt_reg <= '0;
          pulse_reg       <= 1'b0;
          state_reg       <= ST_STARTUP;
        end
        ST_STARTUP: begin
          startup_cnt_reg <= startup_cnt_reg + 1'b1;
          if (startup_cnt_reg == STARTUP_LAST) begin
            reset_out_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
        end
        default: begin
          state_reg     <= ST_INIT;
          pulse_reg     <= 1'b0;
          reset_out_reg <= 1'b0;
          busy_reg      <= 1'b1;
        end
      endcase

      if (running) begin
        if (en) begin
          if (base_cnt_reg == div_q_reg) begin
            base_cnt_reg <= '0;
            div_q_reg    <= div_val;
            pulse_reg    <= 1'b1;
`ifdef CLOCK_PRESCALER_SQUARE_EN
            sq_reg       <= ~sq_reg;
`endif
          end else begin
            base_cnt_reg <= base_cnt_reg + 1'b1;
            pulse_reg    <= 1'b0;
          end
        end else begin
          pulse_reg <= 1'b0;
        end
      end
    end
  end

  prescaler_tick_cascade #(
    .NUM_CH(NUM_CH)
  ) u_cascade (
    .clk     (clk),
    .reset   (reset),
    .clear   (!running),
    .tick    (tick_evt),
    .en      (en),
    .ch_pulse(ch_pulse)
  );

  assign clk_presc_pulse = pulse_reg;
  assign reset_out       = reset_out_reg;
  assign busy_startup    = busy_reg;
`ifdef CLOCK_PRESCALER_SQUARE_EN
  assign clk_presc_sq    = sq_reg;
`endif

endmodule

// File: tb/tb_clock_prescaler_gen.sv
// Directed testbench for clock_prescaler_gen (default parameters).
// Edges are counted from the first rising edge after reset release (cyc).
module tb_clock_prescaler_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] div_val;
  logic       clk_presc_pulse;
  logic [3:0] ch_pulse;
  logic       reset_out;
  logic       busy_startup;
`ifdef CLOCK_PRESCALER_SQUARE_EN
  logic       clk_presc_sq;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Expected ch_pulse for a base tick with tick index mod 8
  logic [3:0] ch_tab [8] = '{4'b0001, 4'b0011, 4'b0001, 4'b0111,
                             4'b0001, 4'b0011, 4'b0001, 4'b1111};

  clock_prescaler_gen dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .div_val        (div_val),
    .clk_presc_pulse(clk_presc_pulse),
    .ch_pulse       (ch_pulse),
    .reset_out      (reset_out),
    .busy_startup   (busy_startup)
`ifdef CLOCK_PRESCALER_SQUARE_EN
    ,
    .clk_presc_sq   (clk_presc_sq)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic release_reset();
    reset = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; div_val = 8'd3;
    repeat (5) step();
    total++; if (clk_presc_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %b want 0", clk_presc_pulse); end
    total++; if (ch_pulse !== 4'b0000) begin bad++; $display("FAIL reset_ch: got %b want 0000", ch_pulse); end
    total++; if (reset_out !== 1'b0) begin bad++; $display("FAIL reset_rout: got %b want 0", reset_out); end
    total++; if (busy_startup !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy_startup); end
    $display("reset: checked outputs held in reset");
  endtask

  // Continue from the current cyc through edge 130; reset_out rises exactly there
  task automatic test_startup();
    logic exp_ro;
    while (cyc < 130) begin
      step();
      exp_ro = (cyc >= 130);
      total++; if (reset_out !== exp_ro) begin bad++; $display("FAIL startup_rout: got %b want %b at cyc %0d", reset_out, exp_ro, cyc); end
      total++; if (busy_startup !== !exp_ro) begin bad++; $display("FAIL startup_busy: got %b want %b at cyc %0d", busy_startup, !exp_ro, cyc); end
    end
    $display("startup: reset_out/busy checked through edge %0d", cyc);
  endtask

  // div_val=3 from INIT: ticks on edges 5,9,13,...; tick index = (cyc-5)/4
  task automatic test_fixed_ratio();
    logic       exp_p;
    logic [3:0] exp_ch;
    while (cyc < 162) begin
      step();
      exp_p  = (cyc % 4 == 1);
      exp_ch = exp_p ? ch_tab[((cyc - 5) / 4) % 8] : 4'b0000;
      total++; if (clk_presc_pulse !== exp_p) begin bad++; $display("FAIL fixed_pulse: got %b want %b at cyc %0d", clk_presc_pulse, exp_p, cyc); end
      total++; if (ch_pulse !== exp_ch) begin bad++; $display("FAIL fixed_ch: got %b want %b at cyc %0d", ch_pulse, exp_ch, cyc); end
    end
    $display("fixed_ratio: div_val=3 window ending cyc %0d checked", cyc);
  endtask

  // Last tick at 161; ratio goes 3->7 after edge 163; ticks at 165, 173, 181
  task automatic test_ratio_change();
    logic       exp_p;
    logic [3:0] exp_ch;
    while (cyc < 163) step();
    div_val = 8'd7;
    while (cyc < 182) begin
      step();
      exp_p  = (cyc == 165) || (cyc == 173) || (cyc == 181);
      exp_ch = exp_p ? ch_tab[(40 + (cyc - 165) / 8) % 8] : 4'b0000;
      total++; if (clk_presc_pulse !== exp_p) begin bad++; $display("FAIL ratio_pulse: got %b want %b at cyc %0d", clk_presc_pulse, exp_p, cyc); end
      total++; if (ch_pulse !== exp_ch) begin bad++; $display("FAIL ratio_ch: got %b want %b at cyc %0d", ch_pulse, exp_ch, cyc); end
    end
    $display("ratio_change: 3->7 mid-period checked");
  endtask

  // div_val=4 takes effect at tick 189; en low for edges 192..201; ticks at 204, 209
  task automatic test_enable_gating();
    logic       exp_p;
    logic [3:0] exp_ch;
    int         idx;
    div_val = 8'd4;
    while (cyc < 210) begin
      step();
      exp_p  = (cyc == 189) || (cyc == 204) || (cyc == 209);
      idx    = (cyc == 189) ? 43 : (cyc == 204) ? 44 : 45;
      exp_ch = exp_p ? ch_tab[idx % 8] : 4'b0000;
      total++; if (clk_presc_pulse !== exp_p) begin bad++; $display("FAIL gate_pulse: got %b want %b at cyc %0d", clk_presc_pulse, exp_p, cyc); end
      total++; if (ch_pulse !== exp_ch) begin bad++; $display("FAIL gate_ch: got %b want %b at cyc %0d", ch_pulse, exp_ch, cyc); end
      if (cyc == 191) en = 1'b0;
      if (cyc == 201) en = 1'b1;
    end
    $display("enable_gating: 10-cycle gap checked");
  endtask

  // div_val=0 reloads at tick 214; afterwards a tick every edge
  task automatic test_div_zero();
    logic       exp_p;
    logic [3:0] exp_ch;
    div_val = 8'd0;
    while (cyc < 222) begin
      step();
      exp_p  = (cyc >= 214);
      exp_ch = exp_p ? ch_tab[(46 + (cyc - 214)) % 8] : 4'b0000;
      total++; if (clk_presc_pulse !== exp_p) begin bad++; $display("FAIL div0_pulse: got %b want %b at cyc %0d", clk_presc_pulse, exp_p, cyc); end
      total++; if (ch_pulse !== exp_ch) begin bad++; $display("FAIL div0_ch: got %b want %b at cyc %0d", ch_pulse, exp_ch, cyc); end
    end
    $display("div_zero: pulse every cycle checked");
  endtask

  task automatic test_reset_mid_active();
    #2;
    reset = 1'b0;
    #1;
    total++; if (clk_presc_pulse !== 1'b0) begin bad++; $display("FAIL async_pulse: got %b want 0", clk_presc_pulse); end
    total++; if (ch_pulse !== 4'b0000) begin bad++; $display("FAIL async_ch: got %b want 0000", ch_pulse); end
    total++; if (reset_out !== 1'b0) begin bad++; $display("FAIL async_rout: got %b want 0", reset_out); end
    total++; if (busy_startup !== 1'b1) begin bad++; $display("FAIL async_busy: got %b want 1", busy_startup); end
    repeat (3) step();
    release_reset();
    step();
    total++; if (clk_presc_pulse !== 1'b0) begin bad++; $display("FAIL restart_init_pulse: got %b want 0", clk_presc_pulse); end
    step();
    total++; if (clk_presc_pulse !== 1'b1) begin bad++; $display("FAIL restart_first_pulse: got %b want 1", clk_presc_pulse); end
    total++; if (ch_pulse !== 4'b0001) begin bad++; $display("FAIL restart_ch0: got %b want 0001", ch_pulse); end
    step();
    total++; if (ch_pulse !== 4'b0011) begin bad++; $display("FAIL restart_ch1: got %b want 0011", ch_pulse); end
    $display("reset_mid_active: async clear and restart checked");
    test_startup();
  endtask

`ifdef CLOCK_PRESCALER_SQUARE_EN
  // div_val=1 reloads at 131; ticks on odd edges, square wave of period 4
  task automatic test_square();
    logic prev_sq;
    int   highs;
    div_val = 8'd1;
    while (cyc < 131) step();
    prev_sq = clk_presc_sq;
    highs   = 0;
    while (cyc < 139) begin
      step();
      total++; if (clk_presc_pulse !== (cyc % 2 == 1)) begin bad++; $display("FAIL sq_pulse: got %b want %b at cyc %0d", clk_presc_pulse, (cyc % 2 == 1), cyc); end
      total++; if (clk_presc_sq !== (prev_sq ^ (cyc % 2 == 1))) begin bad++; $display("FAIL sq_toggle: got %b want %b at cyc %0d", clk_presc_sq, prev_sq ^ (cyc % 2 == 1), cyc); end
      prev_sq = clk_presc_sq;
      if (clk_presc_sq) highs++;
    end
    total++; if (highs != 4) begin bad++; $display("FAIL sq_duty: got %0d want 4 high of 8", highs); end
    $display("square: period-4 square wave checked");
  endtask
`endif

  initial begin
    test_reset();
    release_reset();
    test_startup();
    test_fixed_ratio();
    test_ratio_change();
    test_enable_gating();
    test_div_zero();
    test_reset_mid_active();
`ifdef CLOCK_PRESCALER_SQUARE_EN
    test_square();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_prescaler_gen.md
Name: clock_prescaler_gen

Overview:
Parametrised successor to the fixed divide-by-2 prescaler, with the same startup-reset sequencing. Provides a runtime-programmable base tick divider, an enable, and NUM_CH cascaded sub-rate tick channels at base/2^k. Sits at the top of the RGBW datapath and feeds tick pulses to the PWM/colour blocks. Also drives their synchronous release reset, reset_out.

Parameters:
DIV_WIDTH, 8, width of the divide-ratio input and the base counter
NUM_CH, 4, number of cascaded channel pulses (1..8)
STARTUP_CYCLES, 128, cycles held in STARTUP before reset_out rises (1..2^16-1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
en  input  1  tick enable; 0 freezes all counters
div_val  input  DIV_WIDTH  base period minus one (period = div_val+1 cycles)
clk_presc_pulse  output  1  single-cycle base tick
ch_pulse  output  NUM_CH  ch_pulse[k] = single-cycle tick every 2^k base ticks
reset_out  output  1  active-high "downstream released" flag
busy_startup  output  1  high while the FSM is in INIT or STARTUP

Behaviour:
- Clock and reset: one clock. reset is asynchronous and active-low.
- Reset values (reset=0, asynchronous): state=INIT, base_cnt=0, div_q=0, tick_cnt=0, startup_cnt=0. Outputs: clk_presc_pulse=0, ch_pulse=0, reset_out=0, busy_startup=1.
- FSM states: INIT, STARTUP, ACTIVE. Unused encodings go to INIT on the next edge.
- INIT: one cycle. Loads div_q<=div_val, clears all counters, then goes to STARTUP.
- STARTUP: startup_cnt increments every cycle, independent of en. On the edge where startup_cnt==STARTUP_CYCLES: reset_out<=1, busy_startup<=0, state goes to ACTIVE.
- Startup timing: reset_out rises exactly STARTUP_CYCLES+2 rising edges after the first edge with reset=1.
- ACTIVE: terminal state until reset. reset_out stays 1.
- Base divider: runs in both STARTUP and ACTIVE when en=1.
  - If base_cnt==div_q: base_cnt<=0, div_q<=div_val (reload only at the terminal count, giving glitch-free ratio changes), clk_presc_pulse<=1.
  - Otherwise: base_cnt<=base_cnt+1, clk_presc_pulse<=0.
- Pulse width and latency: the pulse is registered and lasts one cycle. div_val=0 gives a pulse every cycle (1 cycle of latency after INIT).
- div_val changes mid-period: no effect until the current period completes.
- Channels: tick_cnt (NUM_CH-1 bits) increments, with wrap, on each base tick. On that same edge, ch_pulse[k]<=1 iff tick_cnt[k-1:0] is all ones before the increment.
  - ch_pulse[0] equals clk_presc_pulse.
  - All ch_pulse bits assert together on the tick where tick_cnt wraps.
- en=0: base_cnt, tick_cnt and div_q hold. clk_presc_pulse and ch_pulse go 0 on the next edge. When en returns to 1, counting resumes from the held values.
- Reset asserted mid-operation: all state clears immediately. The full startup sequence repeats after release.
- Width rules: all counters are unsigned and wrap modulo 2^width. The base_cnt==div_q compare uses DIV_WIDTH bits.

Optional Feature:
Macro: CLOCK_PRESCALER_SQUARE_EN.
- Defined: adds output clk_presc_sq (1 bit, reset 0). It toggles on every edge where clk_presc_pulse is asserted, giving a square wave at base_rate/2. It holds its value while en=0.
- Undefined: the port and its flop are absent. All other behaviour is identical.

Decomposition:
- Package clock_prescaler_pkg holds:
  - the FSM state localparams INIT=0, STARTUP=1, ACTIVE=2 (2-bit encoding);
  - the default values for DIV_WIDTH, NUM_CH and STARTUP_CYCLES.
- One natural sub-module: prescaler_tick_cascade. It contains tick_cnt and the ch_pulse generation, takes the base tick and en as inputs, and is parametrised by NUM_CH.
- The FSM and base divider stay in the top module.

Test Plan:
- Startup timing: reset low for 5 cycles, release, STARTUP_CYCLES=128 -> reset_out=0 through edge 129, reset_out=1 at edge 130; busy_startup falls on the same edge.
- Fixed ratio: div_val=3, en=1 -> clk_presc_pulse high 1 of every 4 cycles; with NUM_CH=4, ch_pulse[3] fires once per 32 cycles, coincident with ch_pulse[0..2].
- Ratio change mid-period: div_val=3 changed to 7 two cycles after a pulse -> the next pulse arrives 4 cycles after the previous one, then the period becomes 8.
- Enable gating: en=0 for 10 cycles in the middle of a div_val=4 period -> no pulses while gated; after en=1 the remaining count completes with no lost or extra ticks.
- Edge cases:
  - div_val=0 -> pulse every cycle, ch_pulse[1] every 2 cycles;
  - reset asserted mid-ACTIVE -> all outputs 0 immediately (asynchronously), and the startup sequence repeats after release.
- With CLOCK_PRESCALER_SQUARE_EN defined and div_val=1 -> clk_presc_sq has a period of 4 cycles at 50% duty.
